lut_serial_sequencer: RTL and testbench

- Bit-serial controller that time-shares one 2-input function unit across a WIDTH-bit operand pair.
- Per cycle, the function unit computes out = func[{a,b}] (a=0,b=0 -> func[0]; a=0,b=1 -> func[1]; a=1,b=0 -> func[2]; a=1,b=1 -> func[3]).
- Accepts one job over a valid/ready request port, walks the operands LSB-first one bit per cycle, assembles the result word and returns it on a valid/ready result port.
- Sits between a requesting master and the shared combinational function unit, which it instantiates once internally.

---
 rtl/lut_serial_sequencer.sv | 138 +++++++++++++
 tb/tb_lut_serial_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_serial_sequencer.sv
// Bit-serial sequencer sharing one 2-input LUT unit across a WIDTH-bit job.
// Optional res_parity output under `define LUT_SEQ_PARITY_EN.
module lut_fu (
  input  logic [3:0] func_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_o
);
  assign y_o = func_i[{a_i, b_i}];
endmodule

module lut_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_func,
  input  logic             abort,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
`ifdef LUT_SEQ_PARITY_EN
  ,
  output logic             res_parity
`endif
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       func_q, func_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fu_y;

  lut_fu u_fu (
    .func_i (func_q),
    .a_i    (a_q[cnt_q]),
    .b_i    (b_q[cnt_q]),
    .y_o    (fu_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    func_d  = func_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          func_d  = req_func;
          data_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          data_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          data_d[cnt_q] = fu_y;
          // Counter parks on the last index rather than wrapping.
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      data_q  <= data_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = data_q;

`ifdef LUT_SEQ_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (state_q == S_IDLE && req_valid) begin
      par_d = 1'b0;
    end else if (state_q == S_RUN) begin
      par_d = abort ? 1'b0 : (par_q ^ fu_y);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign res_parity = par_q;
`endif
endmodule

// File: tb/tb_lut_serial_sequencer.sv
// Randomized bench for lut_serial_sequencer against a word-level model.
// Covers WIDTH=8 and WIDTH=1 instances.
module tb_lut_serial_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [7:0] req_a, req_b;
  logic [3:0] req_func;
  logic       abort, busy, res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_parity;

  logic       w1_req_valid, w1_req_ready;
  logic [0:0] w1_req_a, w1_req_b;
  logic [3:0] w1_req_func;
  logic       w1_abort, w1_busy, w1_res_valid, w1_res_ready;
  logic [0:0] w1_res_data;
  logic       w1_res_parity;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lut_serial_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_func  (req_func),
    .abort     (abort),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
`ifdef LUT_SEQ_PARITY_EN
    ,
    .res_parity(res_parity)
`endif
  );

  lut_serial_sequencer #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (w1_req_valid),
    .req_ready (w1_req_ready),
    .req_a     (w1_req_a),
    .req_b     (w1_req_b),
    .req_func  (w1_req_func),
    .abort     (w1_abort),
    .busy      (w1_busy),
    .res_valid (w1_res_valid),
    .res_ready (w1_res_ready),
    .res_data  (w1_res_data)
`ifdef LUT_SEQ_PARITY_EN
    ,
    .res_parity(w1_res_parity)
`endif
  );

`ifndef LUT_SEQ_PARITY_EN
  assign res_parity    = 1'b0;
  assign w1_res_parity = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level truth table: OR of the selected minterms.
  function automatic logic [63:0] model(input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic [3:0] f);
    logic [63:0] r;
    r = '0;
    if (f[0]) r = r | (~a & ~b);
    if (f[1]) r = r | (~a & b);
    if (f[2]) r = r | (a & ~b);
    if (f[3]) r = r | (a & b);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] f, input int bp,
                         input bit scr, input bit ia,
                         output logic [7:0] got);
    logic [63:0] m;
    logic [7:0]  exp;
    int n, nbusy;
    m   = model({56'd0, a}, {56'd0, b}, f);
    exp = m[7:0];
    chk("rdy_idle", req_ready, 1);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_func = f;
    abort = ia;
    step();
    req_valid = 1'b0;
    abort = 1'b0;
    n = 0;
    nbusy = 0;
    while (!res_valid && n < 20) begin
      if (busy && !req_ready) nbusy++;
      if (scr) begin
        req_valid = 1'($urandom);
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        req_func = 4'($urandom);
      end
      step();
      n++;
    end
    req_valid = 1'b0;
    chk("latency", n, 8);
    chk("busy_cyc", nbusy, 8);
    chk("data", res_data, exp);
`ifdef LUT_SEQ_PARITY_EN
    chk("parity", res_parity, ^exp);
`endif
    got = res_data;
    for (int i = 0; i < bp; i++) begin
      abort = 1'($urandom);
      step();
      chk("hold_v", res_valid, 1);
      chk("hold_d", res_data, exp);
      chk("hold_rdy", req_ready, 0);
    end
    abort = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("idle_rdy", req_ready, 1);
    chk("idle_v", res_valid, 0);
  endtask

  initial begin
    logic [7:0]  got;
    logic [63:0] m;
    logic        exp1;
    int nv, nr;
    rst_n = 1'b0;
    req_valid = 0; req_a = 0; req_b = 0; req_func = 0;
    abort = 0; res_ready = 0;
    w1_req_valid = 0; w1_req_a = 0; w1_req_b = 0; w1_req_func = 0;
    w1_abort = 0; w1_res_ready = 0;
    #12;
    chk("rst_rdy", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_v", res_valid, 0);
    chk("rst_d", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_job(8'hF0, 8'hCC, 4'b1000, 0, 0, 0, got);
    chk("and", got, 8'hC0);
    run_job(8'hA5, 8'h3C, 4'b0110, 5, 0, 0, got);
    chk("xor", got, 8'h99);
    run_job(8'h07, 8'h00, 4'b1100, 1, 0, 0, got);
    chk("pass_a", got, 8'h07);

    // Abort on the 4th RUN cycle.
    req_valid = 1; req_a = 8'h5A; req_b = 8'h0F; req_func = 4'b1110;
    step();
    req_valid = 0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_rdy", req_ready, 1);
    chk("ab_busy", busy, 0);
    chk("ab_v", res_valid, 0);
    chk("ab_d", res_data, 0);
    nv = 0;
    repeat (10) begin
      step();
      if (res_valid) nv++;
    end
    chk("ab_nov", nv, 0);
    run_job(8'h01, 8'h02, 4'b1110, 0, 1, 0, got);
    chk("or_scr", got, 8'h03);

    // Asynchronous reset mid-RUN after 3 bits.
    req_valid = 1; req_a = 8'hFF; req_b = 8'hFF; req_func = 4'b1000;
    step();
    req_valid = 0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", req_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_v", res_valid, 0);
    chk("arst_d", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_job(8'h3C, 8'h55, 4'b1001, 2, 0, 0, got);

    for (int j = 0; j < 20; j++) begin
      run_job(8'($urandom), 8'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), 1, 1'($urandom), got);
    end

    // WIDTH=1: NOR of 0,0 then back-to-back jobs.
    w1_req_valid = 1; w1_req_a = 0; w1_req_b = 0; w1_req_func = 4'b0001;
    step();
    chk("w1_busy", w1_busy, 1);
    chk("w1_rdy_run", w1_req_ready, 0);
    step();
    chk("w1_v", w1_res_valid, 1);
    chk("w1_d", w1_res_data, 1);
    chk("w1_rdy_done", w1_req_ready, 0);
    w1_res_ready = 1;
    step();
    chk("w1_idle", w1_req_ready, 1);
    nv = 0;
    nr = 0;
    exp1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (w1_req_ready) begin
        nr++;
        w1_req_a = 1'($urandom);
        w1_req_b = 1'($urandom);
        w1_req_func = 4'($urandom);
        m = model({63'd0, w1_req_a}, {63'd0, w1_req_b}, w1_req_func);
        exp1 = m[0];
      end
      if (w1_res_valid) begin
        nv++;
        chk("w1_bb_d", w1_res_data, exp1);
`ifdef LUT_SEQ_PARITY_EN
        chk("w1_par", w1_res_parity, exp1);
`endif
      end
      if (w1_req_ready && (w1_busy || w1_res_valid))
        chk("w1_excl", 1, 0);
      step();
    end
    chk("w1_nvalid", nv, 4);
    chk("w1_nready", nr, 4);
    w1_req_valid = 0;
    step();
    w1_res_ready = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
